// File: rtl/matching_stage_mlane.sv
// Multi-lane matching stage: classifies NUM_LANES words per beat against a FIFO-replaced dictionary.
// Define INTRA_BEAT_FWD_EN to let lane k also match words inserted by lanes <k of the same beat.
module matching_stage_mlane #(
  parameter int unsigned  NUM_LANES  = 2,
  parameter int unsigned  WORD       = 32,
  parameter int unsigned  DICT_ENTRY = 16,
  localparam int unsigned IDX_W      = $clog2(DICT_ENTRY)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [NUM_LANES*WORD-1:0]  i_word,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [NUM_LANES*3-1:0]     o_code,
  output logic [NUM_LANES*6-1:0]     o_length,
  output logic [NUM_LANES*IDX_W-1:0] o_location,
  output logic [NUM_LANES*WORD-1:0]  o_literal,
  output logic                       o_dict_full,
  output logic [IDX_W:0]             o_dict_count
);

  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam logic [5:0]  LEN_FULL = 6'(3 + IDX_W);
  localparam logic [5:0]  LEN_3B   = 6'(3 + IDX_W + 8);
  localparam logic [5:0]  LEN_2B   = 6'(3 + IDX_W + 16);

  logic [WORD-1:0]            dict_q [DICT_ENTRY];
  logic [DICT_ENTRY-1:0]      valid_q, valid_d;
  logic [IDX_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       full_q, full_d;
  logic                       accept;
  logic [NUM_LANES-1:0]       ins_we;
  logic [NUM_LANES*IDX_W-1:0] ins_idx;
  logic [NUM_LANES*3-1:0]     code_d;
  logic [NUM_LANES*6-1:0]     length_d;
  logic [NUM_LANES*IDX_W-1:0] loc_d;
  logic [NUM_LANES*WORD-1:0]  lit_d;

  assign o_ready      = !o_valid || i_ready;
  assign accept       = i_valid && o_ready;
  assign o_dict_count = count_q;
  assign o_dict_full  = full_q;

  // Lanes are walked in order over a working copy of the dictionary; a same-cycle flush starts
  // from an empty dictionary with the pointer at 0.
  always_comb begin : classify
    logic [WORD-1:0]       wdict [DICT_ENTRY];
    logic [DICT_ENTRY-1:0] wvld;
    logic [DICT_ENTRY-1:0] wmask;
    logic [IDX_W-1:0]      ptr;
    logic [WORD-1:0]       w;
    logic                  hit_f, hit_3, hit_2;
    logic [IDX_W-1:0]      loc_f, loc_3, loc_2;
    logic [2:0]            code;
    logic [5:0]            len;
    logic [IDX_W-1:0]      loc;
    logic [WORD-1:0]       lit;
    int unsigned           n_ins;
    int unsigned           cnt_sum;

    wdict    = dict_q;
    wvld     = i_flush ? '0 : valid_q;
    ptr      = i_flush ? '0 : wr_ptr_q;
    wmask    = '0;
    n_ins    = 0;
    code_d   = '0;
    length_d = '0;
    loc_d    = '0;
    lit_d    = '0;
    ins_we   = '0;
    ins_idx  = '0;

    for (int k = 0; k < NUM_LANES; k++) begin
      w     = i_word[k*WORD +: WORD];
      hit_f = 1'b0;
      hit_3 = 1'b0;
      hit_2 = 1'b0;
      loc_f = '0;
      loc_3 = '0;
      loc_2 = '0;
      // Descending scan so the lowest matching index is the last one recorded.
      for (int e = DICT_ENTRY - 1; e >= 0; e--) begin
        if (wvld[e]) begin
          if (wdict[e] == w) begin
            hit_f = 1'b1;
            loc_f = IDX_W'(e);
          end
          if (wdict[e][31:8] == w[31:8]) begin
            hit_3 = 1'b1;
            loc_3 = IDX_W'(e);
          end
          if (wdict[e][31:16] == w[31:16]) begin
            hit_2 = 1'b1;
            loc_2 = IDX_W'(e);
          end
        end
      end

      code = 3'b111;
      len  = 6'd35;
      loc  = '0;
      lit  = w;
      if (w == '0) begin
        code = 3'b000;
        len  = 6'd3;
        lit  = '0;
      end else if (hit_f) begin
        code = 3'b001;
        len  = LEN_FULL;
        loc  = loc_f;
        lit  = '0;
      end else if (hit_3) begin
        code = 3'b010;
        len  = LEN_3B;
        loc  = loc_3;
        lit  = {24'h0, w[7:0]};
      end else if (w[31:8] == 24'h0) begin
        code = 3'b100;
        len  = 6'd11;
        lit  = {24'h0, w[7:0]};
      end else if (hit_2) begin
        code = 3'b011;
        len  = LEN_2B;
        loc  = loc_2;
        lit  = {16'h0, w[15:0]};
      end

      code_d[k*3 +: 3]           = code;
      length_d[k*6 +: 6]         = len;
      loc_d[k*IDX_W +: IDX_W]    = loc;
      lit_d[k*WORD +: WORD]      = lit;

      if (code != 3'b000 && code != 3'b001) begin
        ins_we[k]                 = 1'b1;
        ins_idx[k*IDX_W +: IDX_W] = ptr;
        wmask[ptr]                = 1'b1;
`ifdef INTRA_BEAT_FWD_EN
        wdict[ptr] = w;
        wvld[ptr]  = 1'b1;
`endif
        ptr   = ptr + IDX_W'(1);
        n_ins = n_ins + 1;
      end
    end

    cnt_sum = (i_flush ? 0 : 32'(count_q)) + n_ins;
    if (cnt_sum > DICT_ENTRY) begin
      cnt_sum = DICT_ENTRY;
    end

    if (accept) begin
      valid_d  = (i_flush ? '0 : valid_q) | wmask;
      wr_ptr_d = ptr;
      count_d  = CNT_W'(cnt_sum);
    end else begin
      valid_d  = i_flush ? '0 : valid_q;
      wr_ptr_d = i_flush ? '0 : wr_ptr_q;
      count_d  = i_flush ? '0 : count_q;
    end
    full_d = (i_flush ? 1'b0 : full_q) | (count_d == CNT_W'(DICT_ENTRY));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      o_valid    <= 1'b0;
      o_code     <= '0;
      o_length   <= '0;
      o_location <= '0;
      o_literal  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      if (o_ready) begin
        o_valid <= i_valid;
        if (accept) begin
          o_code     <= code_d;
          o_length   <= length_d;
          o_location <= loc_d;
          o_literal  <= lit_d;
        end
      end
    end
  end

  // Entry data needs no reset: valid_q gates every comparison.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (ins_we[k]) begin
          dict_q[ins_idx[k*IDX_W +: IDX_W]] <= i_word[k*WORD +: WORD];
        end
      end
    end
  end

endmodule
